// File: rtl/key_event_detector_pkg.sv
// key_event_pkg: FSM state encoding and default 50 MHz cycle counts for key_event_detector.
package key_event_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESSED  = 3'd1,
        WAIT_2ND = 3'd2,
        PRESSED2 = 3'd3,
        LONG     = 3'd4
    } state_t;
    localparam int LONG_CYCLES_DEF   = 50_000_000;
    localparam int DCLICK_CYCLES_DEF = 15_000_000;
    localparam int REPEAT_CYCLES_DEF = 10_000_000;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/key_event_detector_timer.sv
// event_timer: shared cycle counter with synchronous clear, enable and terminal-count compare.
module event_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (!rst || clr_i) cnt_q <= '0;
        else if (en_i)     cnt_q <= cnt_q + 1'b1;
    end
    assign done_o = cnt_q == tc_i;
endmodule

// File: rtl/key_event_detector.sv
// key_event_detector: turns the debounced key level into press/release/single/double/long pulses.
// Define KEY_EVENT_REPEAT_EN to enable periodic io_repeat pulses while in LONG.
module key_event_detector
    import key_event_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int DCLICK_CYCLES = DCLICK_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic io_key,
    output logic io_press,
    output logic io_release,
    output logic io_single,
    output logic io_double,
    output logic io_long,
    output logic io_repeat,
    output logic io_held
);
    localparam int W = $clog2(max3(LONG_CYCLES, DCLICK_CYCLES, REPEAT_CYCLES));
    state_t state_q, state_d;
    logic press_q, release_q, single_q, double_q, long_q, rep_q, held_q;
    logic press_d, release_d, single_d, double_d, long_d, rep_d;
    logic clr, en, done;
    logic [W-1:0] tc;
    always_comb begin
        tc = (state_q == WAIT_2ND) ? W'(DCLICK_CYCLES - 1)
           : (state_q == LONG)     ? W'(REPEAT_CYCLES - 1)
           :                         W'(LONG_CYCLES - 1);
    end
    // A key change always takes precedence over a timeout in the same cycle.
    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        single_d  = 1'b0;
        double_d  = 1'b0;
        long_d    = 1'b0;
        rep_d     = 1'b0;
        unique case (state_q)
            IDLE: if (!io_key) begin state_d = PRESSED; press_d = 1'b1; end
            PRESSED:
                if (io_key)    begin state_d = WAIT_2ND; release_d = 1'b1; end
                else if (done) begin state_d = LONG; long_d = 1'b1; end
            WAIT_2ND:
                if (!io_key)   begin state_d = PRESSED2; press_d = 1'b1; end
                else if (done) begin state_d = IDLE; single_d = 1'b1; end
            PRESSED2:
                if (io_key)    begin state_d = IDLE; release_d = 1'b1; double_d = 1'b1; end
                else if (done) begin state_d = LONG; long_d = 1'b1; end
            LONG:
`ifdef KEY_EVENT_REPEAT_EN
                if (io_key)    begin state_d = IDLE; release_d = 1'b1; end
                else if (done) rep_d = 1'b1;
`else
                if (io_key)    begin state_d = IDLE; release_d = 1'b1; end
`endif
            default: state_d = IDLE;
        endcase
    end
    assign clr = (state_d != state_q) || rep_d;
`ifdef KEY_EVENT_REPEAT_EN
    assign en = state_q != IDLE;
`else
    assign en = state_q != IDLE && state_q != LONG;
`endif
    event_timer #(.W(W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr),
        .en_i   (en),
        .tc_i   (tc),
        .done_o (done)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            rep_q     <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            single_q  <= single_d;
            double_q  <= double_d;
            long_q    <= long_d;
            rep_q     <= rep_d;
            held_q    <= state_d == PRESSED || state_d == PRESSED2 || state_d == LONG;
        end
    end
    assign io_press   = press_q;
    assign io_release = release_q;
    assign io_single  = single_q;
    assign io_double  = double_q;
    assign io_long    = long_q;
    assign io_repeat  = rep_q;
    assign io_held    = held_q;
endmodule

// File: tb/tb_key_event_detector.sv
// tb_key_event_detector: directed scenarios for key_event_detector with LONG=20, DCLICK=10, REPEAT=5.
module tb_key_event_detector;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic io_key = 1'b1;
    logic io_press, io_release, io_single, io_double, io_long, io_repeat, io_held;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_press = 0, n_rel = 0, n_single = 0, n_double = 0, n_long = 0, n_rep = 0;
    int t_press = 0, t_rel = 0, t_single = 0, t_double = 0, t_long = 0, t_rep = 0;
    int n_wide = 0, n_excl = 0;
    logic [5:0] prev = '0;

    key_event_detector #(
        .LONG_CYCLES   (20),
        .DCLICK_CYCLES (10),
        .REPEAT_CYCLES (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .io_key     (io_key),
        .io_press   (io_press),
        .io_release (io_release),
        .io_single  (io_single),
        .io_double  (io_double),
        .io_long    (io_long),
        .io_repeat  (io_repeat),
        .io_held    (io_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (io_press)   begin n_press++;  t_press  = cyc; end
        if (io_release) begin n_rel++;    t_rel    = cyc; end
        if (io_single)  begin n_single++; t_single = cyc; end
        if (io_double)  begin n_double++; t_double = cyc; end
        if (io_long)    begin n_long++;   t_long   = cyc; end
        if (io_repeat)  begin n_rep++;    t_rep    = cyc; end
        if (int'(io_single) + int'(io_double) + int'(io_long) > 1) n_excl++;
        if ((prev & {io_press, io_release, io_single, io_double, io_long, io_repeat}) != 6'd0) n_wide++;
        prev = {io_press, io_release, io_single, io_double, io_long, io_repeat};
    end

    task automatic hold(input logic v, input int n);
        io_key = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [6:0] outs;
        outs = {io_press, io_release, io_single, io_double, io_long, io_repeat, io_held};
        checks++; if (outs !== 7'd0) begin errors++; $display("FAIL reset_outs: got %b expected %b", outs, 7'd0); end
        rst = 1'b1;
        hold(1'b1, 3);
        outs = {io_press, io_release, io_single, io_double, io_long, io_repeat, io_held};
        checks++; if (outs !== 7'd0) begin errors++; $display("FAIL idle_outs: got %b expected %b", outs, 7'd0); end
    endtask

    task automatic test_single;
        int p0 = n_press, r0 = n_rel, s0 = n_single, d0 = n_double, l0 = n_long;
        hold(1'b0, 5);
        checks++; if (io_held !== 1'b1) begin errors++; $display("FAIL single_held: got %b expected 1", io_held); end
        hold(1'b1, 15);
        checks++; if (n_press - p0 !== 1) begin errors++; $display("FAIL single_press: got %0d expected 1", n_press - p0); end
        checks++; if (n_rel - r0 !== 1) begin errors++; $display("FAIL single_release: got %0d expected 1", n_rel - r0); end
        checks++; if (t_rel - t_press !== 5) begin errors++; $display("FAIL single_rel_time: got %0d expected 5", t_rel - t_press); end
        checks++; if (n_single - s0 !== 1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", n_single - s0); end
        checks++; if (t_single - t_rel !== 10) begin errors++; $display("FAIL single_time: got %0d expected 10", t_single - t_rel); end
        checks++; if (n_double - d0 + n_long - l0 !== 0) begin errors++; $display("FAIL single_other: got %0d expected 0", n_double - d0 + n_long - l0); end
        checks++; if (io_held !== 1'b0) begin errors++; $display("FAIL single_unheld: got %b expected 0", io_held); end
    endtask

    task automatic test_double;
        int p0 = n_press, r0 = n_rel, s0 = n_single, d0 = n_double;
        hold(1'b0, 3);
        hold(1'b1, 4);
        hold(1'b0, 3);
        hold(1'b1, 14);
        checks++; if (n_press - p0 !== 2) begin errors++; $display("FAIL double_press: got %0d expected 2", n_press - p0); end
        checks++; if (n_rel - r0 !== 2) begin errors++; $display("FAIL double_release: got %0d expected 2", n_rel - r0); end
        checks++; if (n_double - d0 !== 1) begin errors++; $display("FAIL double_cnt: got %0d expected 1", n_double - d0); end
        checks++; if (t_double !== t_rel) begin errors++; $display("FAIL double_time: got %0d expected %0d", t_double, t_rel); end
        checks++; if (t_rel - t_press !== 3) begin errors++; $display("FAIL double_rel2: got %0d expected 3", t_rel - t_press); end
        checks++; if (n_single - s0 !== 0) begin errors++; $display("FAIL double_single: got %0d expected 0", n_single - s0); end
    endtask

    task automatic test_long;
        int r0 = n_rel, s0 = n_single, d0 = n_double, l0 = n_long, k0 = n_rep;
`ifdef KEY_EVENT_REPEAT_EN
        int rep_exp = 2;
`else
        int rep_exp = 0;
`endif
        hold(1'b0, 32);
        checks++; if (io_held !== 1'b1) begin errors++; $display("FAIL long_held: got %b expected 1", io_held); end
        hold(1'b1, 15);
        checks++; if (n_long - l0 !== 1) begin errors++; $display("FAIL long_cnt: got %0d expected 1", n_long - l0); end
        checks++; if (t_long - t_press !== 20) begin errors++; $display("FAIL long_time: got %0d expected 20", t_long - t_press); end
        checks++; if (n_rep - k0 !== rep_exp) begin errors++; $display("FAIL long_repeat: got %0d expected %0d", n_rep - k0, rep_exp); end
        if (rep_exp != 0) begin
            checks++; if (t_rep - t_long !== 10) begin errors++; $display("FAIL long_repeat_time: got %0d expected 10", t_rep - t_long); end
        end
        checks++; if (t_rel - t_press !== 32) begin errors++; $display("FAIL long_release: got %0d expected 32", t_rel - t_press); end
        checks++; if (n_rel - r0 !== 1) begin errors++; $display("FAIL long_rel_cnt: got %0d expected 1", n_rel - r0); end
        checks++; if (n_single - s0 + n_double - d0 !== 0) begin errors++; $display("FAIL long_click: got %0d expected 0", n_single - s0 + n_double - d0); end
    endtask

    task automatic test_boundary;
        int s0 = n_single, l0 = n_long;
        hold(1'b0, 20);
        hold(1'b1, 15);
        checks++; if (n_long - l0 !== 0) begin errors++; $display("FAIL bound_long: got %0d expected 0", n_long - l0); end
        checks++; if (n_single - s0 !== 1) begin errors++; $display("FAIL bound_single: got %0d expected 1", n_single - s0); end
        checks++; if (t_single - t_rel !== 10) begin errors++; $display("FAIL bound_single_time: got %0d expected 10", t_single - t_rel); end
        l0 = n_long; s0 = n_single;
        hold(1'b0, 21);
        hold(1'b1, 15);
        checks++; if (n_long - l0 !== 1) begin errors++; $display("FAIL bound_long21: got %0d expected 1", n_long - l0); end
        checks++; if (n_single - s0 !== 0) begin errors++; $display("FAIL bound_single21: got %0d expected 0", n_single - s0); end
    endtask

    task automatic test_reset_mid;
        int s0 = n_single, e0;
        logic [6:0] outs;
        hold(1'b0, 3);
        hold(1'b1, 4);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        outs = {io_press, io_release, io_single, io_double, io_long, io_repeat, io_held};
        checks++; if (outs !== 7'd0) begin errors++; $display("FAIL rstmid_outs: got %b expected %b", outs, 7'd0); end
        hold(1'b1, 15);
        checks++; if (n_single - s0 !== 0) begin errors++; $display("FAIL rstmid_single: got %0d expected 0", n_single - s0); end
        e0 = cyc;
        hold(1'b0, 1);
        checks++; if (io_press !== 1'b1) begin errors++; $display("FAIL rstmid_press: got %b expected 1", io_press); end
        checks++; if (t_press !== e0 + 1) begin errors++; $display("FAIL rstmid_press_time: got %0d expected %0d", t_press, e0 + 1); end
        hold(1'b1, 14);
    endtask

    task automatic test_reset_held;
        int p0;
        hold(1'b0, 3);
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({io_held, io_press} !== 2'b00) begin errors++; $display("FAIL rsthold_outs: got %b expected 00", {io_held, io_press}); end
        p0 = n_press;
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({io_held, io_press} !== 2'b11) begin errors++; $display("FAIL rsthold_press: got %b expected 11", {io_held, io_press}); end
        checks++; if (n_press - p0 !== 1) begin errors++; $display("FAIL rsthold_cnt: got %0d expected 1", n_press - p0); end
        hold(1'b1, 15);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        test_single;
        test_double;
        test_long;
        test_boundary;
        test_reset_mid;
        test_reset_held;
        checks++; if (n_wide !== 0) begin errors++; $display("FAIL pulse_width: got %0d expected 0", n_wide); end
        checks++; if (n_excl !== 0) begin errors++; $display("FAIL pulse_exclusive: got %0d expected 0", n_excl); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
